// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT back-end stages.
package fft_pkg;

   localparam int FFT_SIZE    = 32;
   localparam int N_WORDS     = FFT_SIZE;
   localparam int WORD_SIZE   = 16;
   localparam int DATA_LENGTH = 8;

   localparam logic [DATA_LENGTH-1:0] SYNC_BYTE = 8'hA5;

   // Serializer FSM: wait for a frame, kick the UART, wait for its done.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } ser_state_t;

endpackage

// File: rtl/frame_byte_sel.sv
// Combinational pick of data byte d from a packed frame of words.
// Byte d comes from word d>>1: low half when d is even, high half when odd.
module frame_byte_sel #(
   parameter int N_WORDS     = fft_pkg::N_WORDS,
   parameter int WORD_SIZE   = fft_pkg::WORD_SIZE,
   parameter int DATA_LENGTH = fft_pkg::DATA_LENGTH,
   parameter int D_W         = $clog2(2 * N_WORDS)
) (
   input  logic [N_WORDS*WORD_SIZE-1:0] i_frame,
   input  logic [D_W-1:0]               i_byte_idx,
   output logic [DATA_LENGTH-1:0]       o_byte
);

   logic [WORD_SIZE-1:0] w_words [N_WORDS];
   logic [WORD_SIZE-1:0] w_word;

   // Unpack the flat frame bus into an addressable word array.
   generate
      for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_unpack
         assign w_words[gi] = i_frame[gi*WORD_SIZE +: WORD_SIZE];
      end
   endgenerate

   // Word select by the upper index bits, half select by the LSB.
   always_comb begin
      w_word = w_words[i_byte_idx[D_W-1:1]];
      o_byte = i_byte_idx[0] ? w_word[DATA_LENGTH +: DATA_LENGTH]
                             : w_word[0 +: DATA_LENGTH];
   end

endmodule

// File: rtl/fft_frame_serializer.sv
// Captures one FFT frame and streams it to the UART transmitter byte by
// byte (optional sync header, then word 0 low byte first). Frames that
// arrive while a transfer is running are rejected and flagged.
module fft_frame_serializer #(
   parameter int                     N_WORDS     = fft_pkg::N_WORDS,
   parameter int                     WORD_SIZE   = fft_pkg::WORD_SIZE,
   parameter int                     DATA_LENGTH = fft_pkg::DATA_LENGTH,
   parameter int                     HEADER_EN   = 1,
   parameter logic [DATA_LENGTH-1:0] SYNC_BYTE   = fft_pkg::SYNC_BYTE
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_frame_valid,
   input  logic [N_WORDS*WORD_SIZE-1:0] i_frame,
   output logic                         o_tx_start,
   output logic [DATA_LENGTH-1:0]       o_tx_byte,
   input  logic                         i_tx_done,
   output logic                         o_busy,
   output logic                         o_frame_done,
   output logic                         o_dropped
);

   localparam int FRAME_W = N_WORDS * WORD_SIZE;
   localparam int N_BYTES = 2 * N_WORDS + HEADER_EN;
   localparam int IDX_W   = $clog2(N_BYTES);
   localparam int D_W     = $clog2(2 * N_WORDS);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

   fft_pkg::ser_state_t r_state, w_state_next;

   logic [IDX_W-1:0]       r_idx, w_idx_next;
   logic [FRAME_W-1:0]     r_frame_q, w_frame_next;
   logic                   r_frame_done, w_frame_done_next;
   logic                   r_dropped, w_dropped_next;
   logic [D_W-1:0]         w_data_idx;
   logic [DATA_LENGTH-1:0] w_data_byte;
   logic [DATA_LENGTH-1:0] w_sel_byte;
   logic                   w_is_header;

   // State, byte index, frame store and status pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= fft_pkg::IDLE;
         r_idx        <= '0;
         r_frame_q    <= '0;
         r_frame_done <= 1'b0;
         r_dropped    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_idx        <= w_idx_next;
         r_frame_q    <= w_frame_next;
         r_frame_done <= w_frame_done_next;
         r_dropped    <= w_dropped_next;
      end
   end

   // Next-state logic: accept in IDLE, one start per byte, advance on done.
   always_comb begin
      w_state_next      = r_state;
      w_idx_next        = r_idx;
      w_frame_next      = r_frame_q;
      w_frame_done_next = 1'b0;
      // Any frame offered outside IDLE is lost; flag it one cycle later.
      w_dropped_next    = i_frame_valid && (r_state != fft_pkg::IDLE);

      case (r_state)
         fft_pkg::IDLE: begin
            if (i_frame_valid) begin
               w_frame_next = i_frame;
               w_idx_next   = '0;
               w_state_next = fft_pkg::SEND;
            end
         end
         fft_pkg::SEND: begin
            w_state_next = fft_pkg::WAIT;
         end
         fft_pkg::WAIT: begin
            if (i_tx_done) begin
               if (r_idx == LAST_IDX) begin
                  w_frame_done_next = 1'b1;
                  w_idx_next        = '0;
                  w_state_next      = fft_pkg::IDLE;
               end else begin
                  w_idx_next   = r_idx + 1'b1;
                  w_state_next = fft_pkg::SEND;
               end
            end
         end
         default: begin
            w_state_next = fft_pkg::IDLE;
         end
      endcase
   end

   // Header slot only exists when the sync byte is enabled.
   generate
      if (HEADER_EN != 0) begin : g_hdr
         assign w_is_header = (r_idx == '0);
      end else begin : g_no_hdr
         assign w_is_header = 1'b0;
      end
   endgenerate

   // Data byte number is the transmit index minus the header slot.
   assign w_data_idx = D_W'(r_idx - IDX_W'(HEADER_EN));

   frame_byte_sel #(
      .N_WORDS     (N_WORDS),
      .WORD_SIZE   (WORD_SIZE),
      .DATA_LENGTH (DATA_LENGTH),
      .D_W         (D_W)
   ) u_byte_sel (
      .i_frame    (r_frame_q),
      .i_byte_idx (w_data_idx),
      .o_byte     (w_data_byte)
   );

   assign w_sel_byte = w_is_header ? SYNC_BYTE : w_data_byte;

   // Byte bus held at zero while idle so it reads 0 out of reset.
   assign o_tx_byte    = (r_state != fft_pkg::IDLE) ? w_sel_byte : '0;
   assign o_tx_start   = (r_state == fft_pkg::SEND);
   assign o_busy       = (r_state != fft_pkg::IDLE);
   assign o_frame_done = r_frame_done;
   assign o_dropped    = r_dropped;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Scoreboard bench: stimulus pushes expected bytes/markers, per-DUT
// monitors pop and compare on every o_tx_start / o_frame_done.
module tb_fft_frame_serializer;

   localparam int NW = 32;
   localparam int WS = 16;
   localparam int FW = NW * WS;
   localparam int MARK_DONE = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Header-enabled instance signals
   logic          h_fv = 1'b0;
   logic [FW-1:0] h_fr = '0;
   logic          h_start, h_busy, h_fdone, h_drop;
   logic [7:0]    h_byte;
   logic          h_model_done = 1'b0, h_spur = 1'b0;
   logic          h_done;
   assign h_done = h_model_done | h_spur;

   // Header-disabled instance signals
   logic          n_fv = 1'b0;
   logic [FW-1:0] n_fr = '0;
   logic          n_start, n_busy, n_fdone, n_drop;
   logic [7:0]    n_byte;
   logic          n_model_done = 1'b0, n_spur = 1'b0;
   logic          n_done;
   assign n_done = n_model_done | n_spur;

   fft_frame_serializer #(.HEADER_EN(1)) dut_h (
      .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(h_fv), .i_frame(h_fr),
      .o_tx_start(h_start), .o_tx_byte(h_byte), .i_tx_done(h_done),
      .o_busy(h_busy), .o_frame_done(h_fdone), .o_dropped(h_drop)
   );

   fft_frame_serializer #(.HEADER_EN(0)) dut_n (
      .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(n_fv), .i_frame(n_fr),
      .o_tx_start(n_start), .o_tx_byte(n_byte), .i_tx_done(n_done),
      .o_busy(n_busy), .o_frame_done(n_fdone), .o_dropped(n_drop)
   );

   int checks = 0;
   int errors = 0;
   int qh[$];
   int qn[$];
   int h_starts = 0, n_starts = 0;
   int h_drops = 0, n_drops = 0;
   int h_exp_v, n_exp_v;
   logic h_prev_done = 1'b0, h_prev_fv = 1'b0;
   logic n_prev_done = 1'b0, n_prev_fv = 1'b0;
   logic [7:0] h_last_byte = '0, n_last_byte = '0;

   function void check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endfunction

   function logic [FW-1:0] rand_frame();
      logic [FW-1:0] r;
      for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   // Expected order for a captured frame: header, then each word low/high.
   task push_frame_h(input logic [FW-1:0] f);
      qh.push_back(8'hA5);
      for (int k = 0; k < NW; k++) begin
         qh.push_back(int'(f[k*WS +: 8]));
         qh.push_back(int'(f[k*WS + 8 +: 8]));
      end
      qh.push_back(MARK_DONE);
   endtask

   // UART models: done pulse sampled 5 edges after the start cycle.
   initial begin
      forever begin
         @(posedge clk); #1;
         while (h_start) begin
            repeat (4) @(posedge clk);
            #1 h_model_done = 1'b1;
            @(posedge clk);
            #1 h_model_done = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         while (n_start) begin
            repeat (4) @(posedge clk);
            #1 n_model_done = 1'b1;
            @(posedge clk);
            #1 n_model_done = 1'b0;
         end
      end
   end

   // Monitor for the header-enabled instance.
   always @(negedge clk) begin
      if (!rst_n) begin
         h_starts = 0;
         h_prev_done = 1'b0;
         h_prev_fv = 1'b0;
      end else begin
         if (h_done && h_busy && !h_start)
            check("h_byte_stable", int'(h_byte), int'(h_last_byte));
         if (h_start) begin
            check("h_busy_with_start", int'(h_busy), 1);
            if (qh.size() == 0) begin
               checks++; errors++;
               $display("FAIL h_unexpected_start: got byte %02h required no start", h_byte);
            end else begin
               h_exp_v = qh.pop_front();
               check("h_byte", int'(h_byte), h_exp_v);
               $display("h byte %0d = %02h", h_starts, h_byte);
            end
            h_last_byte = h_byte;
            h_starts++;
         end
         if (h_fdone) begin
            if (qh.size() == 0) begin
               checks++; errors++;
               $display("FAIL h_unexpected_frame_done: got pulse required none");
            end else begin
               h_exp_v = qh.pop_front();
               check("h_frame_done_order", h_exp_v, MARK_DONE);
            end
            check("h_frame_done_after_done", int'(h_prev_done), 1);
            check("h_start_count", h_starts, 65);
            $display("h frame done after %0d bytes", h_starts);
            h_starts = 0;
         end
         if (h_drop) begin
            h_drops++;
            check("h_drop_after_valid", int'(h_prev_fv), 1);
            $display("h frame dropped");
         end
         h_prev_done = h_done;
         h_prev_fv = h_fv;
      end
   end

   // Monitor for the header-disabled instance.
   always @(negedge clk) begin
      if (!rst_n) begin
         n_starts = 0;
         n_prev_done = 1'b0;
         n_prev_fv = 1'b0;
      end else begin
         if (n_done && n_busy && !n_start)
            check("n_byte_stable", int'(n_byte), int'(n_last_byte));
         if (n_start) begin
            if (qn.size() == 0) begin
               checks++; errors++;
               $display("FAIL n_unexpected_start: got byte %02h required no start", n_byte);
            end else begin
               n_exp_v = qn.pop_front();
               check("n_byte", int'(n_byte), n_exp_v);
               $display("n byte %0d = %02h", n_starts, n_byte);
            end
            n_last_byte = n_byte;
            n_starts++;
         end
         if (n_fdone) begin
            if (qn.size() == 0) begin
               checks++; errors++;
               $display("FAIL n_unexpected_frame_done: got pulse required none");
            end else begin
               n_exp_v = qn.pop_front();
               check("n_frame_done_order", n_exp_v, MARK_DONE);
            end
            check("n_frame_done_after_done", int'(n_prev_done), 1);
            check("n_start_count", n_starts, 64);
            $display("n frame done after %0d bytes", n_starts);
            n_starts = 0;
         end
         if (n_drop) begin
            n_drops++;
            check("n_drop_after_valid", int'(n_prev_fv), 1);
         end
         n_prev_done = n_done;
         n_prev_fv = n_fv;
      end
   end

   // Frame offer on the header instance, with a spurious done in SEND.
   task send_h(input logic [FW-1:0] f);
      h_fv = 1'b1;
      h_fr = f;
      @(posedge clk); #1;
      h_fv = 1'b0;
      h_fr = rand_frame();
      h_spur = 1'b1;
      @(posedge clk); #1;
      h_spur = 1'b0;
   endtask

   task wait_starts_h(input int target);
      int budget;
      budget = 3000;
      while (h_starts < target && budget > 0) begin
         @(negedge clk); #1;
         budget--;
      end
      if (budget == 0) begin
         checks++; errors++;
         $display("FAIL h_wait_starts: got %0d starts required %0d", h_starts, target);
      end
   endtask

   task wait_empty_h();
      int budget;
      budget = 3000;
      while (qh.size() != 0 && budget > 0) begin
         @(negedge clk); #1;
         budget--;
      end
      if (budget == 0) begin
         checks++; errors++;
         $display("FAIL h_wait_empty: got %0d pending required 0", qh.size());
      end
   endtask

   task wait_empty_n();
      int budget;
      budget = 3000;
      while (qn.size() != 0 && budget > 0) begin
         @(negedge clk); #1;
         budget--;
      end
      if (budget == 0) begin
         checks++; errors++;
         $display("FAIL n_wait_empty: got %0d pending required 0", qn.size());
      end
   endtask

   task check_outputs_zero_h(input string tag);
      check({tag, "_busy"}, int'(h_busy), 0);
      check({tag, "_tx_start"}, int'(h_start), 0);
      check({tag, "_tx_byte"}, int'(h_byte), 0);
      check({tag, "_frame_done"}, int'(h_fdone), 0);
      check({tag, "_dropped"}, int'(h_drop), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [FW-1:0] fa, fb, fc, fd, fe, ff, fn;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero_h("reset");
      check("reset_n_busy", int'(n_busy), 0);
      check("reset_n_tx_byte", int'(n_byte), 0);
      rst_n = 1'b1;

      // Spurious done while idle must not start anything
      @(posedge clk); #1;
      h_spur = 1'b1;
      n_spur = 1'b1;
      @(posedge clk); #1;
      h_spur = 1'b0;
      n_spur = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("idle_spur_busy", int'(h_busy), 0);

      // Frame A: word k = 0x0101*k -> A5, 00,00, 01,01, ... 1F,1F
      for (int k = 0; k < NW; k++) fa[k*WS +: WS] = 16'(k * 257);
      qh.push_back(8'hA5);
      for (int k = 0; k < NW; k++) begin
         qh.push_back(k);
         qh.push_back(k);
      end
      qh.push_back(MARK_DONE);
      send_h(fa);
      wait_empty_h();

      // Frame B, with frame C offered during byte index 10 (dropped)
      fb = rand_frame();
      fc = rand_frame();
      @(posedge clk); #1;
      push_frame_h(fb);
      send_h(fb);
      wait_starts_h(11);
      @(posedge clk); #1;
      h_fv = 1'b1;
      h_fr = fc;
      @(posedge clk); #1;
      h_fv = 1'b0;
      wait_empty_h();

      // Frame C offered in the frame-done cycle: must be accepted
      push_frame_h(fc);
      send_h(fc);
      wait_empty_h();

      // Frame D, then a frame offered on the same edge as the final done
      fd = rand_frame();
      @(posedge clk); #1;
      push_frame_h(fd);
      send_h(fd);
      wait_starts_h(65);
      repeat (4) @(posedge clk);
      #1;
      h_fv = 1'b1;
      h_fr = rand_frame();
      @(posedge clk); #1;
      h_fv = 1'b0;
      repeat (12) @(posedge clk); #1;
      check("coincide_idle_busy", int'(h_busy), 0);

      // Frame E, reset asserted during byte index 20
      fe = rand_frame();
      push_frame_h(fe);
      send_h(fe);
      wait_starts_h(21);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero_h("midrst");
      qh.delete();
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk); #1;
      check("post_reset_busy", int'(h_busy), 0);

      // Frame F restarts from the header
      ff = rand_frame();
      push_frame_h(ff);
      send_h(ff);
      wait_empty_h();

      // Header-disabled: word0=1234, word31=BEEF, others 0x0101*k
      for (int k = 0; k < NW; k++) fn[k*WS +: WS] = 16'(k * 257);
      fn[0 +: WS] = 16'h1234;
      fn[31*WS +: WS] = 16'hBEEF;
      qn.push_back(8'h34);
      qn.push_back(8'h12);
      for (int k = 1; k < NW - 1; k++) begin
         qn.push_back(k);
         qn.push_back(k);
      end
      qn.push_back(8'hEF);
      qn.push_back(8'hBE);
      qn.push_back(MARK_DONE);
      @(posedge clk); #1;
      n_fv = 1'b1;
      n_fr = fn;
      @(posedge clk); #1;
      n_fv = 1'b0;
      n_fr = rand_frame();
      wait_empty_n();

      repeat (10) @(posedge clk); #1;
      check("h_queue_drained", qh.size(), 0);
      check("n_queue_drained", qn.size(), 0);
      check("h_drop_count", h_drops, 2);
      check("n_drop_count", n_drops, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_frame_serializer.md
# fft_frame_serializer

Downstream stage of the 32-point FFT core. On the FFT's one-cycle frame-done pulse, captures all 32 real-part output words into an internal frame register, then streams them as 64 bytes (word 0 first, low byte first), optionally preceded by a sync header byte, to the UART transmitter through its start/done handshake. It replaces the 64-to-1 mux and the ad-hoc transmit sequencing around the UART. Frames that arrive while a transfer is in progress are dropped and flagged.

## Interface
- N_WORDS, 32, FFT output words per frame
- WORD_SIZE, 16, bits per word; must equal 2*DATA_LENGTH
- DATA_LENGTH, 8, UART byte width
- HEADER_EN, 1, 1 = send SYNC_BYTE before the data bytes
- SYNC_BYTE, 8'hA5, header value

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_frame_valid  in  1  one-cycle pulse: i_frame holds a complete FFT result
- i_frame  in  N_WORDS*WORD_SIZE  word k at bits [k*WORD_SIZE +: WORD_SIZE]
- o_tx_start  out  1  one-cycle pulse to UART_TX i_start
- o_tx_byte  out  DATA_LENGTH  byte to UART_TX i_TX_byte
- i_tx_done  in  1  one-cycle pulse from UART_TX o_TX_done
- o_busy  out  1  transfer in progress
- o_frame_done  out  1  one-cycle pulse after the last byte completes
- o_dropped  out  1  one-cycle pulse: frame rejected because busy

## Operation
- States: IDLE, SEND, WAIT.
- IDLE: o_busy=0. On i_frame_valid, latch i_frame into frame_q, set idx=0 (header slot when HEADER_EN=1), go to SEND.
- SEND: assert o_tx_start for exactly one cycle, go to WAIT.
- WAIT: on i_tx_done, if idx is the last index, pulse o_frame_done and go to IDLE. Otherwise idx+1 and go to SEND. i_tx_done in IDLE or SEND is ignored.
- Byte order:
  - Total bytes B = 2*N_WORDS + HEADER_EN (65 by default).
  - Data byte d (0..2*N_WORDS-1) = frame_q word d>>1: low half if d even, high half if d odd.
  - With HEADER_EN, idx 0 is SYNC_BYTE and data byte d is at idx d+1.
- o_tx_byte is a function of registered idx and frame_q only. It is stable from the SEND cycle until the i_tx_done that ends that byte.
- i_frame_valid while o_busy=1: frame not captured, frame_q unchanged, o_dropped pulses the next cycle.
- frame_q is only written on an accepted frame. Input may change freely after the capture cycle.

## Timing
- Reset values: state IDLE, idx 0, frame_q 0, o_tx_start 0, o_tx_byte 0, o_busy 0, o_frame_done 0, o_dropped 0.
- i_frame_valid at edge t (IDLE): o_busy=1 and o_tx_start=1 in cycle t+1. o_tx_byte is valid in the same cycle.
- i_tx_done sampled at edge u (not last byte): o_tx_start=1 in cycle u+1 with the next byte. There is exactly one cycle between done and the next start.
- Last i_tx_done at edge u: o_frame_done=1 and o_busy=0 in cycle u+1. A new i_frame_valid is accepted at edge u+1.
- i_frame_valid coinciding with the last i_tx_done (edge u): o_busy is still 1 at that edge, so the frame is dropped.
- i_rst_n low mid-transfer: immediate return to reset values. No further o_tx_start until a new frame after release.
- idx width is clog2(B). idx never exceeds B-1; there is no wrap.

## Structure
- Shared package fft_pkg holds:
  - FFT_SIZE / N_WORDS, WORD_SIZE, DATA_LENGTH
  - SYNC_BYTE
  - the serializer state encoding (IDLE/SEND/WAIT)
- One sub-module, frame_byte_sel: combinational selection of byte d from frame_q (parameterised N_WORDS/WORD_SIZE). It replaces the hand-written 64-input mux.
- The FSM, idx counter and frame_q register live in fft_frame_serializer.

## Test plan
- Word k = 16'h0100*k + k, with an auto-responding UART model (done 5 cycles after start).
  - Required bytes: A5, 00, 00, 01, 01, 02, 02, … 1F, 1F (65 bytes).
  - o_frame_done pulses once, 1 cycle after the 65th done.
- HEADER_EN=0, word0=16'h1234, word31=16'hBEEF → first byte 34, second 12, last two EF, BE. Exactly 64 starts.
- Second i_frame_valid during byte 10:
  - o_dropped pulses 1 cycle later.
  - Remaining bytes still come from the first frame.
  - After o_frame_done, a new frame is accepted and transmitted.
- i_frame_valid on the same edge as the final i_tx_done → o_dropped=1, returns to IDLE, no o_tx_start.
- Spurious i_tx_done pulses in IDLE and in the SEND cycle → ignored; byte count and order unchanged.
- Assert i_rst_n=0 during byte 20:
  - All outputs go to 0 asynchronously.
  - After release, no o_tx_start until the next i_frame_valid.
  - The next frame restarts from the header.
